// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: drives an HD44780-style parallel LCD bus with one write
// cycle per request, then waits for the panel. With LCD_BUSY_POLL_EN defined
// the wait is a busy-flag poll loop. Without it, the wait is a fixed delay.
//
// Request handshake: a request transfers on any rising clk edge where
// req_valid and req_ready are both 1. req_ready is 1 only in IDLE, and
// req_rs/req_data are latched on that edge. The requester must hold
// req_valid, req_rs and req_data stable until the transfer.
module lcd_bus_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 2,
  parameter int POLL_LIMIT     = 4095,
  parameter int FIXED_WAIT_CYC = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in,
  output logic [6:0] addr_count,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_EHI, W_HOLD, P_SETUP, P_EHI, P_HOLD, F_WAIT
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EHI_LAST   = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(FIXED_WAIT_CYC - 1);
  localparam logic [11:0] POLL_LIM   = 12'(POLL_LIMIT);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic        ready_en;
  logic        lat_rs;
  logic [7:0]  lat_data;
  logic [7:0]  rd_byte;
  logic [11:0] poll_cnt;
  logic        hs, last, sample, poll_exit, poll_ok, poll_to;

  assign state_dbg = state;

  // Next state, phase-end strobes and bus outputs decoded from the state.
  // Bus pins are a pure function of state, so a reset edge drops E at once.
  always_comb begin
    state_next   = state;
    last         = 1'b0;
    hs           = 1'b0;
    sample       = 1'b0;
    poll_exit    = 1'b0;
    poll_ok      = 1'b0;
    poll_to      = 1'b0;
    req_ready    = 1'b0;
    LCD_E        = 1'b0;
    LCD_RS       = 1'b0;
    LCD_RW       = 1'b0;
    LCD_data_oe  = 1'b0;
    LCD_data_out = 8'h00;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        hs        = req_valid & ready_en;
        if (hs) state_next = W_SETUP;
      end
      W_SETUP, W_EHI, W_HOLD: begin
        LCD_RS       = lat_rs;
        LCD_data_oe  = 1'b1;
        LCD_data_out = lat_data;
        LCD_E        = (state == W_EHI);
        if (state == W_SETUP) begin
          last = (cnt == SETUP_LAST);
          if (last) state_next = W_EHI;
        end else if (state == W_EHI) begin
          last = (cnt == EHI_LAST);
          if (last) state_next = W_HOLD;
        end else begin
          last = (cnt == HOLD_LAST);
`ifdef LCD_BUSY_POLL_EN
          if (last) state_next = P_SETUP;
`else
          if (last) state_next = F_WAIT;
`endif
        end
      end
      P_SETUP: begin
        LCD_RW = 1'b1;
        last   = (cnt == SETUP_LAST);
        if (last) state_next = P_EHI;
      end
      P_EHI: begin
        LCD_RW = 1'b1;
        LCD_E  = 1'b1;
        last   = (cnt == EHI_LAST);
        sample = last;
        if (last) state_next = P_HOLD;
      end
      P_HOLD: begin
        LCD_RW    = 1'b1;
        last      = (cnt == HOLD_LAST);
        poll_exit = last;
        if (last) begin
          if (!rd_byte[7]) begin
            poll_ok    = 1'b1;
            state_next = IDLE;
          end else if (poll_cnt < POLL_LIM) begin
            state_next = P_SETUP;
          end else begin
            poll_to    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      F_WAIT: begin
        last = (cnt == WAIT_LAST);
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, phase counter, request latch and poll bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      ready_en    <= 1'b0;
      lat_rs      <= 1'b0;
      lat_data    <= 8'h00;
      rd_byte     <= 8'h00;
      poll_cnt    <= 12'd0;
      addr_count  <= 7'd0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (state_next != state || state == IDLE) cnt <= 16'd0;
      else                                      cnt <= cnt + 16'd1;
      if (hs) begin
        lat_rs   <= req_rs;
        lat_data <= req_data;
        poll_cnt <= 12'd0;
      end else if (poll_exit && poll_cnt != 12'hFFF) begin
        poll_cnt <= poll_cnt + 12'd1;
      end
      if (sample)  rd_byte    <= LCD_data_in;
      if (poll_ok) addr_count <= rd_byte[6:0];
      timeout_err <= poll_to;
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: directed bench for lcd_bus_sequencer. It checks
// poll-mode items when LCD_BUSY_POLL_EN is defined and fixed-wait items
// otherwise. The panel is modelled as a number of busy reads followed by a
// ready byte.
module tb_lcd_bus_sequencer;

`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL_ON = 1'b1;
`else
  localparam bit POLL_ON = 1'b0;
`endif
  // quick panel: 16 write + 16 poll + 1 idle; fixed wait: 16 + 2000 + 1
  localparam int LAT_QUICK = POLL_ON ? 33 : 2017;
  localparam int LAT_BUSY4 = 16 + 4 * 16 + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       LCD_E, LCD_RS, LCD_RW, LCD_data_oe;
  logic [7:0] LCD_data_out, LCD_data_in;
  logic [6:0] addr_count;
  logic       timeout_err;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;

  // panel model state
  int         busy_reads = 0;
  int         rd_base = 0;
  logic [7:0] busy_val = 8'h80;
  logic [7:0] ok_val = 8'h00;

  // monitor counters
  int   wr_pulses = 0, rd_done = 0, e_high = 0, to_cnt = 0, hs_cnt = 0, viol = 0;
  logic prev_e = 1'b0, prev_rs = 1'b0, prev_rw = 1'b0, prev_oe = 1'b0;

  lcd_bus_sequencer #(.POLL_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_data(req_data), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
    .LCD_data_in(LCD_data_in), .addr_count(addr_count),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // panel read data: busy byte for the first busy_reads reads, then ok_val
  always_comb LCD_data_in = ((rd_done - rd_base) < busy_reads) ? busy_val : ok_val;

  // bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (LCD_E && !prev_e && !LCD_RW) wr_pulses++;
      if (!LCD_E && prev_e && prev_rw) rd_done++;
      if (LCD_E) e_high++;
      if (timeout_err) to_cnt++;
      if (req_valid && req_ready) hs_cnt++;
      if (LCD_data_oe && LCD_RW) viol++;
      if ((LCD_E || prev_e) &&
          (LCD_RS != prev_rs || LCD_RW != prev_rw || LCD_data_oe != prev_oe)) viol++;
    end
    prev_e  = LCD_E;
    prev_rs = LCD_RS;
    prev_rw = LCD_RW;
    prev_oe = LCD_data_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int k = 0;
    while (!req_ready && k < 3000) begin
      tick();
      k++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue one request and walk it; lat = cycles from handshake to ready.
  // With keep=1, req_valid stays high carrying (nrs, nd) as the next request.
  task automatic do_req(input logic rs, input logic [7:0] d, input logic keep,
                        input logic nrs, input logic [7:0] nd, output int lat);
    int n;
    wait_ready();
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    tick();
    if (keep) begin
      req_rs   = nrs;
      req_data = nd;
    end else begin
      req_valid = 1'b0;
    end
    chk("setup_e", {31'd0, LCD_E}, 32'd0);
    chk("setup_rs", {31'd0, LCD_RS}, {31'd0, rs});
    chk("setup_rw", {31'd0, LCD_RW}, 32'd0);
    chk("setup_oe", {31'd0, LCD_data_oe}, 32'd1);
    chk("setup_data", {24'd0, LCD_data_out}, {24'd0, d});
    chk("setup_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) tick();
    chk("ehi_first", {31'd0, LCD_E}, 32'd1);
    repeat (11) tick();
    chk("ehi_last", {31'd0, LCD_E}, 32'd1);
    tick();
    chk("hold_e", {31'd0, LCD_E}, 32'd0);
    chk("hold_oe", {31'd0, LCD_data_oe}, 32'd1);
    chk("hold_data", {24'd0, LCD_data_out}, {24'd0, d});
    repeat (2) tick();
    chk("done_e", {31'd0, LCD_E}, 32'd0);
    chk("done_oe", {31'd0, LCD_data_oe}, 32'd0);
    chk("done_rw", {31'd0, LCD_RW}, {31'd0, POLL_ON});
    n = 17;
    while (!req_ready && n < 3000) begin
      tick();
      n++;
    end
    lat = n;
  endtask

  int lat, lat2, w0, r0, e0, t0, h0;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_e", {31'd0, LCD_E}, 32'd0);
    chk("rst_rs", {31'd0, LCD_RS}, 32'd0);
    chk("rst_rw", {31'd0, LCD_RW}, 32'd0);
    chk("rst_oe", {31'd0, LCD_data_oe}, 32'd0);
    chk("rst_data", {24'd0, LCD_data_out}, 32'd0);
    chk("rst_addr", {25'd0, addr_count}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // instruction write 0x38, quick panel reply 0x05
    busy_reads = 0; ok_val = 8'h05; rd_base = rd_done;
    w0 = wr_pulses; r0 = rd_done; e0 = e_high; t0 = to_cnt;
    do_req(1'b0, 8'h38, 1'b0, 1'b0, 8'h00, lat);
    chk("instr_latency", lat, LAT_QUICK);
    chk("instr_wr_pulses", wr_pulses - w0, 1);
    chk("instr_rd_pulses", rd_done - r0, POLL_ON ? 1 : 0);
    chk("instr_e_high", e_high - e0, POLL_ON ? 24 : 12);
    chk("instr_addr", {25'd0, addr_count}, POLL_ON ? 32'h05 : 32'h00);
    chk("instr_timeout", to_cnt - t0, 0);

    // data write 0x48 (busy panel: 3 busy reads then 0x10)
    busy_reads = 3; busy_val = 8'h80; ok_val = 8'h10; rd_base = rd_done;
    w0 = wr_pulses; r0 = rd_done; t0 = to_cnt;
    do_req(1'b1, 8'h48, 1'b0, 1'b0, 8'h00, lat);
    chk("data_latency", lat, POLL_ON ? LAT_BUSY4 : 2017);
    chk("data_wr_pulses", wr_pulses - w0, 1);
    chk("data_rd_pulses", rd_done - r0, POLL_ON ? 4 : 0);
    chk("data_addr", {25'd0, addr_count}, POLL_ON ? 32'h10 : 32'h00);
    chk("data_timeout", to_cnt - t0, 0);

`ifdef LCD_BUSY_POLL_EN
    // stuck busy panel with POLL_LIMIT=3
    busy_reads = 100000; busy_val = 8'hFF; rd_base = rd_done;
    r0 = rd_done; t0 = to_cnt;
    do_req(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, lat);
    chk("stuck_latency", lat, LAT_BUSY4);
    chk("stuck_rd_pulses", rd_done - r0, 4);
    chk("stuck_timeout", to_cnt - t0, 1);
    chk("stuck_addr", {25'd0, addr_count}, 32'h10);
    chk("stuck_idle_ready", {31'd0, req_ready}, 32'd1);
`endif

    // reset on the 5th cycle of the write E pulse
    wait_ready();
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("abort_pre_e", {31'd0, LCD_E}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_e", {31'd0, LCD_E}, 32'd0);
    chk("abort_oe", {31'd0, LCD_data_oe}, 32'd0);
    chk("abort_data", {24'd0, LCD_data_out}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    w0 = wr_pulses;
    repeat (20) tick();
    chk("abort_no_e", wr_pulses - w0, 0);

    // back-to-back: req_valid held high across two requests
    busy_reads = 0; ok_val = 8'h22; rd_base = rd_done;
    h0 = hs_cnt; w0 = wr_pulses;
    do_req(1'b1, 8'h41, 1'b1, 1'b0, 8'h42, lat);
    chk("b2b_gap", lat, LAT_QUICK);
    chk("b2b_hs_first", hs_cnt - h0, 1);
    do_req(1'b0, 8'h42, 1'b0, 1'b0, 8'h00, lat2);
    chk("b2b_latency2", lat2, LAT_QUICK);
    chk("b2b_hs_total", hs_cnt - h0, 2);
    chk("b2b_wr_pulses", wr_pulses - w0, 2);
    chk("b2b_addr", {25'd0, addr_count}, POLL_ON ? 32'h22 : 32'h00);

    chk("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
